// File: rtl/ddr_sched_pkg.sv
// Shared command codes, scheduler state encoding and length helper for the
// DDR ring-buffer burst scheduler.
package ddr_sched_pkg;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    ST_WAIT_CAL,
    ST_ARB,
    ST_REQ,
    ST_RUN,
    ST_FIN
  } sched_state_t;

  function automatic logic [31:0] min3(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/ddr_cpl_sync.sv
// Brings the asynchronous acquisition-complete level into ddr_ui_clk and
// emits a one-cycle pulse on its rising edge.
module ddr_cpl_sync (
  input  logic ddr_ui_clk,
  input  logic ddr_log_rst_n,
  input  logic complete,
  output logic complete_rise
);

  // [0],[1] form the synchroniser; [2] holds the previous synchronised value
  logic [2:0] sync_q;

  always_ff @(posedge ddr_ui_clk or negedge ddr_log_rst_n) begin
    if (!ddr_log_rst_n) sync_q <= '0;
    else                sync_q <= {sync_q[1:0], complete};
  end

  assign complete_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ddr_burst_sched.sv
// Ring-buffer burst scheduler: arbitrates write/read bursts to the DDR command
// engine, tracks wrap-around pointers and runs the end-of-acquisition flush.
//
// state    | meaning
// WAIT_CAL | waiting for MIG calibration
// ARB      | choose next burst, or finish when flush has drained
// REQ      | burst presented, waiting for engine ack
// RUN      | burst accepted, waiting for engine done
// FIN      | one-cycle finish pulse, flush latch cleared
module ddr_burst_sched
  import ddr_sched_pkg::*;
#(
  parameter int ADDR_WIDTH     = 30,
  parameter int BURST_LEN      = 128,
  parameter int ADDR_INC       = 8,
  parameter int BUF_BASE       = 0,
  parameter int BUF_BEATS_LOG2 = 22,
  parameter int UP_URGENT      = 768
) (
  input  logic                      ddr_ui_clk,
  input  logic                      ddr_log_rst_n,
  input  logic                      init_calib_complete,
  input  logic                      complete,
  input  logic [9:0]                i_rd_data_count,
  input  logic [9:0]                i_dn_free,
  output logic                      o_burst_req,
  output logic [2:0]                o_burst_cmd,
  output logic [ADDR_WIDTH-1:0]     o_burst_addr,
  output logic [7:0]                o_burst_len,
  input  logic                      i_burst_ack,
  input  logic                      i_burst_done,
  output logic                      o_rd_data_finish,
  output logic [BUF_BEATS_LOG2:0]   o_fill_level,
  output logic                      o_busy
);

  localparam int          PW        = BUF_BEATS_LOG2 + 1;
  localparam logic [31:0] BUF_BEATS = 32'(1) << BUF_BEATS_LOG2;
  localparam logic [31:0] BL        = 32'(BURST_LEN);

  sched_state_t state_q, state_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, fill;
  logic [BUF_BEATS_LOG2-1:0] sel_ptr;
  logic flush_q, last_wr_q, complete_rise;
  logic [31:0] fill32, free32, cnt32, dn32, wr_cap, rd_cap, wr_len, rd_len, rd_need;
  logic wr_ok, rd_ok, pick_wr, launch, burst_end;

  ddr_cpl_sync u_cpl_sync (
    .ddr_ui_clk    (ddr_ui_clk),
    .ddr_log_rst_n (ddr_log_rst_n),
    .complete      (complete),
    .complete_rise (complete_rise)
  );

  assign fill    = wr_ptr_q - rd_ptr_q;
  assign fill32  = 32'(fill);
  assign free32  = BUF_BEATS - fill32;
  assign cnt32   = 32'(i_rd_data_count);
  assign dn32    = 32'(i_dn_free);
  // bursts stop at the end of the buffer so the engine never sees a wrap
  assign wr_cap  = BUF_BEATS - 32'(wr_ptr_q[BUF_BEATS_LOG2-1:0]);
  assign rd_cap  = BUF_BEATS - 32'(rd_ptr_q[BUF_BEATS_LOG2-1:0]);
  assign wr_len  = min3(cnt32, BL, (free32 < wr_cap) ? free32 : wr_cap);
  assign rd_len  = min3(fill32, BL, rd_cap);
  assign rd_need = (fill32 < BL) ? fill32 : BL;

  assign wr_ok = flush_q ? (cnt32 != 0 && free32 != 0)
                         : (cnt32 >= BL && fill32 <= BUF_BEATS - BL);
  assign rd_ok = flush_q ? (fill32 != 0 && dn32 >= rd_need)
                         : (fill32 >= BL && dn32 >= BL);
  assign pick_wr = wr_ok && (!rd_ok || cnt32 >= 32'(UP_URGENT) || !last_wr_q);
  assign sel_ptr = pick_wr ? wr_ptr_q[BUF_BEATS_LOG2-1:0] : rd_ptr_q[BUF_BEATS_LOG2-1:0];

  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    burst_end = 1'b0;
    unique case (state_q)
      ST_WAIT_CAL: if (init_calib_complete) state_d = ST_ARB;
      ST_ARB: begin
        if (flush_q && cnt32 == 0 && fill32 == 0) begin
          state_d = ST_FIN;
        end else if (wr_ok || rd_ok) begin
          state_d = ST_REQ;
          launch  = 1'b1;
        end
      end
      ST_REQ: begin
        if (i_burst_ack) begin
          burst_end = i_burst_done;
          state_d   = i_burst_done ? ST_ARB : ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_burst_done) begin
          burst_end = 1'b1;
          state_d   = ST_ARB;
        end
      end
      ST_FIN:  state_d = ST_ARB;
      default: state_d = ST_WAIT_CAL;
    endcase
  end

  always_ff @(posedge ddr_ui_clk or negedge ddr_log_rst_n) begin
    if (!ddr_log_rst_n) begin
      state_q      <= ST_WAIT_CAL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      flush_q      <= 1'b0;
      last_wr_q    <= 1'b0;
      o_burst_cmd  <= CMD_WR;
      o_burst_addr <= '0;
      o_burst_len  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FIN)  flush_q <= 1'b0;
      else if (complete_rise) flush_q <= 1'b1;
      if (launch) begin
        o_burst_cmd  <= pick_wr ? CMD_WR : CMD_RD;
        o_burst_addr <= ADDR_WIDTH'(BUF_BASE) + ADDR_WIDTH'(sel_ptr) * ADDR_WIDTH'(ADDR_INC);
        o_burst_len  <= 8'(pick_wr ? wr_len : rd_len);
      end
      if (state_q == ST_REQ && i_burst_ack) last_wr_q <= (o_burst_cmd == CMD_WR);
      if (burst_end) begin
        if (o_burst_cmd == CMD_WR) wr_ptr_q <= wr_ptr_q + PW'(o_burst_len);
        else                       rd_ptr_q <= rd_ptr_q + PW'(o_burst_len);
      end
    end
  end

  assign o_burst_req      = (state_q == ST_REQ);
  assign o_rd_data_finish = (state_q == ST_FIN);
  assign o_busy           = (state_q == ST_REQ) || (state_q == ST_RUN) || (state_q == ST_FIN);
  assign o_fill_level     = fill;

endmodule

// File: tb/tb_ddr_burst_sched.sv
// Directed + randomized bench for ddr_burst_sched; a 1024-beat buffer keeps
// wrap and full-buffer cases within a short run.
module tb_ddr_burst_sched;

  localparam int LOG2 = 10;
  localparam int BB   = 1 << LOG2;
  localparam int BL   = 128;

  logic clk = 1'b0, rst_n = 1'b1, cal = 1'b0, complete = 1'b0, ack = 1'b0, done = 1'b0;
  logic [9:0] cnt = '0, dn = '0;
  logic req, fin, busy;
  logic [2:0] cmd;
  logic [29:0] addr;
  logic [7:0] len;
  logic [LOG2:0] fill;

  int checks = 0, errors = 0;
  int wp = 0, rp = 0, fin_seen = 0;
  bit flush = 1'b0, last_wr = 1'b0;

  ddr_burst_sched #(.BUF_BEATS_LOG2(LOG2)) dut (
    .ddr_ui_clk          (clk),
    .ddr_log_rst_n       (rst_n),
    .init_calib_complete (cal),
    .complete            (complete),
    .i_rd_data_count     (cnt),
    .i_dn_free           (dn),
    .o_burst_req         (req),
    .o_burst_cmd         (cmd),
    .o_burst_addr        (addr),
    .o_burst_len         (len),
    .i_burst_ack         (ack),
    .i_burst_done        (done),
    .o_rd_data_finish    (fin),
    .o_fill_level        (fill),
    .o_busy              (busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (fin) fin_seen++;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference: decide the next burst from the buffer rules and service it as the engine.
  task automatic step(input string tag);
    int c, d, fm, fr, wlen, rlen, elen, eptr, n;
    bit wok, rok, pw, same, seen;
    logic [2:0] ecmd;
    logic [29:0] eaddr;
    c  = int'(cnt);
    d  = int'(dn);
    fm = wp - rp;
    fr = BB - fm;
    wok  = flush ? (c > 0 && fr > 0) : (c >= BL && fm <= BB - BL);
    rok  = flush ? (fm > 0 && d >= imin(fm, BL)) : (fm >= BL && d >= BL);
    wlen = imin(imin(c, BL), imin(fr, BB - (wp % BB)));
    rlen = imin(imin(fm, BL), BB - (rp % BB));
    if (wok && rok) pw = (c >= 768) || !last_wr;
    else            pw = wok;
    if (!wok && !rok) begin
      seen = 1'b0;
      repeat (8) begin
        tick();
        seen |= req;
      end
      chk({tag, "/no_req"}, 64'(seen), 64'(0));
      chk({tag, "/idle_busy"}, 64'(busy), 64'(0));
      return;
    end
    eptr  = pw ? (wp % BB) : (rp % BB);
    elen  = pw ? wlen : rlen;
    ecmd  = pw ? 3'd0 : 3'd1;
    eaddr = 30'(eptr * 8);
    n = 0;
    while (!req && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "/req"}, 64'(req), 64'(1));
    if (!req) return;
    chk({tag, "/cmd"}, 64'(cmd), 64'(ecmd));
    chk({tag, "/addr"}, 64'(addr), 64'(eaddr));
    chk({tag, "/len"}, 64'(len), 64'(elen));
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk({tag, "/hold"}, 64'({req, cmd, addr, len}), 64'({1'b1, ecmd, eaddr, 8'(elen)}));
    end
    same = ($urandom_range(0, 3) == 0);
    ack  = 1'b1;
    done = same;
    tick();
    ack  = 1'b0;
    done = 1'b0;
    if (!same) begin
      repeat ($urandom_range(0, 3)) tick();
      chk({tag, "/run"}, 64'({busy, req}), 64'(2'b10));
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    if (pw) wp += elen;
    else    rp += elen;
    last_wr = pw;
    chk({tag, "/fill"}, 64'(fill), 64'(wp - rp));
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    cnt = 10'd128;
    tick();
    tick();
    chk("reset_outputs", 64'({req, cmd, addr, len, fin, fill, busy}), 64'(0));
    rst_n = 1'b1;
    repeat (5) tick();
    chk("wait_cal_no_req", 64'({req, busy}), 64'(0));
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("stray_done", 64'(fill), 64'(0));

    cal = 1'b1;
    step("first_wr");
    chk("first_wr_const", 64'({cmd, addr, len}), 64'({3'd0, 30'd0, 8'd128}));
    dn = 10'd0;
    step("second_wr");

    cnt = 10'd200;
    dn  = 10'd200;
    step("rr0"); chk("rr0_cmd", 64'(cmd), 64'(1));
    step("rr1"); chk("rr1_cmd", 64'(cmd), 64'(0));
    step("rr2"); chk("rr2_cmd", 64'(cmd), 64'(1));
    step("rr3"); chk("rr3_cmd", 64'(cmd), 64'(0));
    cnt = 10'd800;
    step("urg0"); chk("urg0_cmd", 64'(cmd), 64'(0));
    step("urg1"); chk("urg1_cmd", 64'(cmd), 64'(0));

    cnt = 10'd64;
    dn  = 10'd0;
    step("pre_flush");
    complete = 1'b1;
    repeat (5) tick();
    flush = 1'b1;
    step("flush_wr");
    chk("flush_wr_const", 64'({cmd, addr, len}), 64'({3'd0, 30'd6144, 8'd64}));
    cnt = 10'd0;
    dn  = 10'd1023;
    n = 0;
    while (wp - rp >= BL && n < 20) begin
      step("flush_rd");
      n++;
    end
    dn = 10'(wp - rp - 1);
    step("flush_dn_short");
    dn = 10'(wp - rp);
    step("flush_tail");
    chk("flush_tail_len", 64'(len), 64'(64));
    repeat (4) tick();
    chk("finish_once_1", 64'(fin_seen), 64'(1));
    flush = 1'b0;
    complete = 1'b0;

    cnt = 10'd128;
    dn  = 10'd0;
    step("pre_wrap");
    step("wrap_edge");
    chk("wrap_edge_const", 64'({addr, len}), 64'({30'd7680, 8'd64}));
    step("wrap_zero");
    chk("wrap_zero_addr", 64'(addr), 64'(0));
    repeat (6) step("fill_up");

    cnt = 10'd0;
    complete = 1'b1;
    repeat (5) tick();
    flush = 1'b1;
    cnt = 10'd1000;
    step("to_full");
    chk("full_level", 64'(fill), 64'(BB));
    step("full_stall");
    dn = 10'd128;
    step("full_read");
    chk("full_read_const", 64'({cmd, len}), 64'({3'd1, 8'd128}));
    cnt = 10'd0;
    dn  = 10'd1023;
    n = 0;
    while (wp - rp > 0 && n < 20) begin
      step("drain");
      n++;
    end
    repeat (4) tick();
    chk("finish_once_2", 64'(fin_seen), 64'(2));
    flush = 1'b0;
    complete = 1'b0;

    for (int i = 0; i < 40; i++) begin
      cnt = 10'($urandom_range(0, 1023));
      dn  = 10'($urandom_range(0, 1023));
      step("rand");
    end

    cnt = 10'd1023;
    dn  = 10'd1023;
    n = 0;
    while (!req && n < 20) begin
      tick();
      n++;
    end
    chk("pre_reset_req", 64'(req), 64'(1));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    rst_n = 1'b0;
    cal   = 1'b0;
    cnt   = 10'd128;
    #1;
    chk("reset_in_run", 64'({req, cmd, addr, len, fin, fill, busy}), 64'(0));
    tick();
    rst_n = 1'b1;
    wp = 0;
    rp = 0;
    last_wr = 1'b0;
    repeat (6) tick();
    chk("post_reset_quiet", 64'({req, busy, fill}), 64'(0));
    cal = 1'b1;
    step("post_reset_wr");
    chk("post_reset_const", 64'({cmd, addr, len}), 64'({3'd0, 30'd0, 8'd128}));
    chk("finish_total", 64'(fin_seen), 64'(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
